jtopll_buswr: RTL and testbench
===============================

JTOPLL_BUSWR -- requirements
Module: jtopll_buswr

Interface
REQ-001 SHALL have parameter ADDR_WAIT, default 12, minimum number of cen periods between end of address strobe and start of data strobe.
REQ-002 SHALL have parameter DATA_WAIT, default 84, minimum number of cen periods between end of data strobe and start of the next address strobe.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cen, input, 1, clock enable shared with the OPLL core; all timing counts in cen periods.
REQ-006 SHALL have port in_valid, input, 1, host request to queue one register write.
REQ-007 SHALL have port in_reg, input, 6, OPLL register index.
REQ-008 SHALL have port in_data, input, 8, register value.
REQ-009 SHALL have port in_ready, output, 1, queue can accept a write; equals !full.
REQ-010 SHALL have port dout, output, 8, data bus to OPLL din.
REQ-011 SHALL have port addr, output, 1, bus address select (0 = index, 1 = data).
REQ-012 SHALL have port cs_n, output, 1, active-low chip select.
REQ-013 SHALL have port wr_n, output, 1, active-low write strobe.
REQ-014 SHALL have port idle, output, 1, high when queue empty and FSM in IDLE.

Function
REQ-015 SHALL contain a 4-entry FIFO of {reg, data}; push on any clk edge with in_valid && in_ready, cen not required.
REQ-016 SHALL reject pushes while full, even on a cycle where a pop occurs; in_ready SHALL be combinational !full.
REQ-017 SHALL issue writes in strict FIFO order, never popping when empty.
REQ-018 SHALL implement states IDLE, ADR_STB, ADR_WAIT, DAT_STB, DAT_WAIT; transitions and output changes SHALL occur only on clk edges with cen=1.
REQ-019 IDLE: if FIFO non-empty, pop; addr=0, dout={2'b0,reg}, cs_n=0, wr_n=0; go ADR_STB.
REQ-020 ADR_STB: cs_n=wr_n=1; load wait counter with ADDR_WAIT; go ADR_WAIT.
REQ-021 ADR_WAIT: decrement counter each cen; on the cen where counter reaches 0 after exactly ADDR_WAIT high periods, set addr=1, dout=data, cs_n=wr_n=0; go DAT_STB.
REQ-022 DAT_STB: cs_n=wr_n=1; load counter with DATA_WAIT; go DAT_WAIT.
REQ-023 DAT_WAIT: after exactly DATA_WAIT high cen periods go IDLE; IDLE SHALL start the next write on that same cen if FIFO non-empty (no extra bubble).
REQ-024 Strobes (cs_n, wr_n) SHALL be low for exactly one cen period and always asserted/deasserted together.
REQ-025 dout and addr SHALL hold their last value while strobes are high.
REQ-026 Counter width SHALL fit max(ADDR_WAIT, DATA_WAIT); ADDR_WAIT and DATA_WAIT >= 1 SHALL be supported.
REQ-027 With cen=1, a write SHALL occupy ADDR_WAIT+DATA_WAIT+2 clk cycles from address strobe to earliest next address strobe.
REQ-028 idle SHALL be registered-equivalent: high only when state is IDLE and FIFO count is 0.

Reset
REQ-029 On rst asserted, asynchronously: cs_n=1, wr_n=1, addr=0, dout=0x00, state IDLE, FIFO emptied, counter 0; hence in_ready=1, idle=1.
REQ-030 Reset mid-operation SHALL abandon the in-flight write and discard queued entries; no strobe SHALL follow reset release until a new push.

Verification
REQ-031 Single write, cen=1, defaults: push reg 0x10 data 0x55 -> cycle t addr=0 dout=0x10 strobe low 1 clk; cycle t+13 addr=1 dout=0x55 strobe low 1 clk; idle=1 from t+98.
REQ-032 Burst: 5 consecutive pushes with no prior pops -> first 4 accepted, in_ready=0 on 5th; in_ready returns 1 the cycle after first pop; all 4 writes emitted in order, address strobes 98 clk apart.
REQ-033 cen 1-in-4: single write -> strobes 4 clk wide, data strobe starts 52 clk after address strobe start, idle 392 clk after start.
REQ-034 Reset during DAT_WAIT with 2 entries queued -> cs_n=wr_n=1 immediately, idle=1, in_ready=1, no further strobes after release.
REQ-035 Boundary ADDR_WAIT=1, DATA_WAIT=1, cen=1: two queued writes -> address strobes at t and t+4, data strobes at t+2 and t+6.
REQ-036 Full-plus-pop: FIFO full, in_valid=1 on the pop cycle -> push rejected, next cycle accepted.

Source files
------------

// File: rtl/jtopll_buswr.sv
// Queues OPLL register writes and replays them on the chip bus as an
// address strobe followed by a data strobe, honouring the chip's wait times.
module jtopll_buswr #(
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       in_valid,
  input  logic [5:0] in_reg,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] dout,
  output logic       addr,
  output logic       cs_n,
  output logic       wr_n,
  output logic       idle
);

  localparam int unsigned MaxWait = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAdrStb,
    StAdrWait,
    StDatStb,
    StDatWait
  } state_e;

  // FIFO of {reg, data}
  logic [13:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        full, empty, push, pop;
  logic [13:0] head;

  assign full     = (count_q == 3'd4);
  assign empty    = (count_q == 3'd0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_reg, in_data};
  end

  // Bus sequencer
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      data_q, data_d;
  logic            addr_q, addr_d;
  logic            strb_n_q, strb_n_d;
  logic            start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    data_d   = data_q;
    addr_d   = addr_q;
    strb_n_d = strb_n_q;
    start    = 1'b0;
    pop      = 1'b0;
    if (cen) begin
      unique case (state_q)
        StIdle: start = 1'b1;
        StAdrStb: begin
          strb_n_d = 1'b1;
          cnt_d    = CntW'(ADDR_WAIT);
          state_d  = StAdrWait;
        end
        StAdrWait: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q <= CntW'(1)) begin
            addr_d   = 1'b1;
            dout_d   = data_q;
            strb_n_d = 1'b0;
            state_d  = StDatStb;
          end
        end
        StDatStb: begin
          strb_n_d = 1'b1;
          cnt_d    = CntW'(DATA_WAIT);
          state_d  = StDatWait;
        end
        StDatWait: begin
          cnt_d = cnt_q - CntW'(1);
          // Last wait period doubles as IDLE so back-to-back writes have no bubble
          if (cnt_q <= CntW'(1)) begin
            state_d = StIdle;
            start   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (start && !empty) begin
        pop      = 1'b1;
        addr_d   = 1'b0;
        dout_d   = {2'b00, head[13:8]};
        data_d   = head[7:0];
        strb_n_d = 1'b0;
        state_d  = StAdrStb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dout_q   <= '0;
      data_q   <= '0;
      addr_q   <= 1'b0;
      strb_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      strb_n_q <= strb_n_d;
    end
  end

  // One register drives both strobes so they can never split
  assign cs_n = strb_n_q;
  assign wr_n = strb_n_q;
  assign dout = dout_q;
  assign addr = addr_q;
  assign idle = (state_q == StIdle) && empty;

endmodule

// File: tb/tb_jtopll_buswr.sv
// Directed bench for jtopll_buswr: default timing, burst/full FIFO, slow cen,
// mid-operation reset and the minimum-wait corner on a second instance.
module tb_jtopll_buswr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_valid_b = 1'b0;
  logic [5:0] in_reg = '0;
  logic [7:0] in_data = '0;
  logic       in_ready, addr, cs_n, wr_n, idle;
  logic [7:0] dout;
  logic       in_ready_b, addr_b, cs_n_b, wr_n_b, idle_b;
  logic [7:0] dout_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cen_div = 1;
  int phase = 0;

  jtopll_buswr u_dut (
    .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .in_reg(in_reg),
    .in_data(in_data), .in_ready(in_ready), .dout(dout), .addr(addr),
    .cs_n(cs_n), .wr_n(wr_n), .idle(idle)
  );

  jtopll_buswr #(.ADDR_WAIT(1), .DATA_WAIT(1)) u_dut_b (
    .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid_b), .in_reg(in_reg),
    .in_data(in_data), .in_ready(in_ready_b), .dout(dout_b), .addr(addr_b),
    .cs_n(cs_n_b), .wr_n(wr_n_b), .idle(idle_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cen pattern: 0 = held low, N = one pulse every N clocks
  always @(negedge clk) begin
    #1;
    if (cen_div == 0) cen = 1'b0;
    else begin
      cen   = (phase == 0);
      phase = (phase + 1) % cen_div;
    end
  end

  // Strobe recorders
  int         ev_start[$];
  int         ev_len[$];
  logic       ev_addr[$];
  logic [7:0] ev_dout[$];
  bit         in_low = 0;
  int         wr_mis = 0;
  int         evb_start[$];
  logic       evb_addr[$];
  logic [7:0] evb_dout[$];
  bit         in_low_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_low   = 0;
      in_low_b = 0;
    end else begin
      if (cs_n !== wr_n) wr_mis++;
      if (!cs_n) begin
        if (!in_low) begin
          ev_start.push_back(cyc);
          ev_len.push_back(1);
          ev_addr.push_back(addr);
          ev_dout.push_back(dout);
          in_low = 1;
        end else ev_len[ev_len.size()-1] = ev_len[ev_len.size()-1] + 1;
      end else in_low = 0;
      if (!cs_n_b) begin
        if (!in_low_b) begin
          evb_start.push_back(cyc);
          evb_addr.push_back(addr_b);
          evb_dout.push_back(dout_b);
          in_low_b = 1;
        end
      end else in_low_b = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_events();
    ev_start.delete();
    ev_len.delete();
    ev_addr.delete();
    ev_dout.delete();
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (idle) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL idle_timeout got=busy exp=idle within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", cs_n); end
    checks++; if (wr_n !== 1'b1) begin failures++; $display("FAIL rst_wr_n got=%b exp=1", wr_n); end
    checks++; if (addr !== 1'b0) begin failures++; $display("FAIL rst_addr got=%b exp=0", addr); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", dout); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
  endtask

  task automatic test_single();
    int at;
    clear_events();
    in_valid = 1; in_reg = 6'h10; in_data = 8'h55;
    tick();
    in_valid = 0;
    wait_idle(300, at);
    checks++; if (ev_start.size() != 2) begin failures++; $display("FAIL single_count got=%0d exp=2", ev_start.size()); end
    if (ev_start.size() == 2) begin
      checks++; if (ev_addr[0] !== 1'b0 || ev_dout[0] !== 8'h10) begin failures++; $display("FAIL single_adr got=%b/%h exp=0/10", ev_addr[0], ev_dout[0]); end
      checks++; if (ev_addr[1] !== 1'b1 || ev_dout[1] !== 8'h55) begin failures++; $display("FAIL single_dat got=%b/%h exp=1/55", ev_addr[1], ev_dout[1]); end
      checks++; if (ev_len[0] != 1 || ev_len[1] != 1) begin failures++; $display("FAIL single_width got=%0d/%0d exp=1/1", ev_len[0], ev_len[1]); end
      checks++; if (ev_start[1] - ev_start[0] != 13) begin failures++; $display("FAIL single_dat_delay got=%0d exp=13", ev_start[1] - ev_start[0]); end
      checks++; if (at - ev_start[0] != 98) begin failures++; $display("FAIL single_idle_delay got=%0d exp=98", at - ev_start[0]); end
    end
    checks++; if (wr_mis != 0) begin failures++; $display("FAIL strobe_pair got=%0d exp=0 splits", wr_mis); end
  endtask

  task automatic test_burst();
    int at;
    clear_events();
    cen_div = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_reg = 6'(1 + i); in_data = 8'hA1 + 8'(i);
      checks++; if (in_ready !== (i < 4)) begin failures++; $display("FAIL burst_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
      tick();
    end
    in_valid = 0;
    phase = 0; cen_div = 1;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL burst_ready_full got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || ev_start.size() != 1) begin failures++; $display("FAIL burst_ready_after_pop got=%b/%0d exp=1/1", in_ready, ev_start.size()); end
    wait_idle(600, at);
    checks++; if (ev_start.size() != 8) begin failures++; $display("FAIL burst_count got=%0d exp=8", ev_start.size()); end
    if (ev_start.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_addr[2*i] !== 1'b0 || ev_dout[2*i] !== 8'(1 + i) || ev_addr[2*i+1] !== 1'b1 ||
            ev_dout[2*i+1] !== 8'hA1 + 8'(i) || ev_start[2*i] - ev_start[0] != 98 * i) begin
          failures++;
          $display("FAIL burst_write[%0d] got=%h/%h@%0d exp=%h/%h@%0d", i, ev_dout[2*i],
                   ev_dout[2*i+1], ev_start[2*i] - ev_start[0], 8'(1 + i), 8'hA1 + 8'(i), 98 * i);
        end
      end
    end
  endtask

  task automatic test_cen4();
    int at;
    clear_events();
    phase = 0; cen_div = 4;
    tick();
    in_valid = 1; in_reg = 6'h2A; in_data = 8'hC3;
    tick();
    in_valid = 0;
    wait_idle(1000, at);
    checks++; if (ev_start.size() != 2) begin failures++; $display("FAIL cen4_count got=%0d exp=2", ev_start.size()); end
    if (ev_start.size() == 2) begin
      checks++; if (ev_len[0] != 4 || ev_len[1] != 4) begin failures++; $display("FAIL cen4_width got=%0d/%0d exp=4/4", ev_len[0], ev_len[1]); end
      checks++; if (ev_start[1] - ev_start[0] != 52) begin failures++; $display("FAIL cen4_dat_delay got=%0d exp=52", ev_start[1] - ev_start[0]); end
      checks++; if (at - ev_start[0] != 392) begin failures++; $display("FAIL cen4_idle_delay got=%0d exp=392", at - ev_start[0]); end
      checks++; if (ev_dout[0] !== 8'h2A || ev_dout[1] !== 8'hC3) begin failures++; $display("FAIL cen4_data got=%h/%h exp=2a/c3", ev_dout[0], ev_dout[1]); end
    end
  endtask

  task automatic test_full_pop();
    int at;
    clear_events();
    cen_div = 0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_reg = 6'h08 + 6'(i); in_data = 8'hB0 + 8'(i);
      tick();
    end
    in_valid = 0;
    phase = 0; cen_div = 1;
    tick();
    in_valid = 1; in_reg = 6'h0C; in_data = 8'hB4;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_ready_pop got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_ready_next got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_refull got=%b exp=0", in_ready); end
    wait_idle(800, at);
    checks++; if (ev_start.size() != 10) begin failures++; $display("FAIL fullpop_count got=%0d exp=10", ev_start.size()); end
    if (ev_start.size() == 10) begin
      checks++; if (ev_dout[8] !== 8'h0C || ev_dout[9] !== 8'hB4) begin failures++; $display("FAIL fullpop_last got=%h/%h exp=0c/b4", ev_dout[8], ev_dout[9]); end
      checks++; if (ev_dout[6] !== 8'h0B || ev_dout[7] !== 8'hB3) begin failures++; $display("FAIL fullpop_fourth got=%h/%h exp=0b/b3", ev_dout[6], ev_dout[7]); end
    end
  endtask

  task automatic test_boundary();
    cen_div = 1;
    evb_start.delete(); evb_addr.delete(); evb_dout.delete();
    tick();
    in_valid_b = 1; in_reg = 6'h11; in_data = 8'h22;
    tick();
    in_reg = 6'h33; in_data = 8'h44;
    tick();
    in_valid_b = 0;
    repeat (20) tick();
    checks++; if (evb_start.size() != 4) begin failures++; $display("FAIL bnd_count got=%0d exp=4", evb_start.size()); end
    if (evb_start.size() == 4) begin
      checks++; if (evb_start[1] - evb_start[0] != 2 || evb_start[2] - evb_start[0] != 4 ||
                    evb_start[3] - evb_start[0] != 6) begin
        failures++;
        $display("FAIL bnd_timing got=%0d/%0d/%0d exp=2/4/6", evb_start[1] - evb_start[0],
                 evb_start[2] - evb_start[0], evb_start[3] - evb_start[0]);
      end
      checks++; if (evb_addr[0] !== 1'b0 || evb_addr[1] !== 1'b1 || evb_addr[2] !== 1'b0 || evb_addr[3] !== 1'b1) begin failures++; $display("FAIL bnd_addr got=%b%b%b%b exp=0101", evb_addr[0], evb_addr[1], evb_addr[2], evb_addr[3]); end
      checks++; if (evb_dout[0] !== 8'h11 || evb_dout[1] !== 8'h22 || evb_dout[2] !== 8'h33 || evb_dout[3] !== 8'h44) begin failures++; $display("FAIL bnd_data got=%h %h %h %h exp=11 22 33 44", evb_dout[0], evb_dout[1], evb_dout[2], evb_dout[3]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_events();
    cen_div = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_reg = 6'h20 + 6'(i); in_data = 8'hD0 + 8'(i);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 100 && ev_start.size() < 2; i++) tick();
    repeat (20) tick();
    @(negedge clk);
    #3 rst = 1;
    #1;
    checks++; if (cs_n !== 1'b1 || wr_n !== 1'b1) begin failures++; $display("FAIL rstmid_strobe got=%b%b exp=11", cs_n, wr_n); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%b exp=1", idle); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    checks++; if (addr !== 1'b0 || dout !== 8'h00) begin failures++; $display("FAIL rstmid_bus got=%b/%h exp=0/00", addr, dout); end
    n = ev_start.size();
    tick();
    rst = 0;
    repeat (300) tick();
    checks++; if (ev_start.size() != n || n != 2) begin failures++; $display("FAIL rstmid_no_strobe got=%0d exp=2 events", ev_start.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle_after got=%b exp=1", idle); end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    rst = 0;
    tick();
    test_single();
    test_burst();
    test_cen4();
    test_full_pop();
    test_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
